// File: rtl/uart_rx_fifo_receiver_pkg.sv
// rtl/uart_rx_fifo_receiver_pkg.sv - shared types and constants for the UART receive front end
// Receiver state encoding, frame data width and baud divider helpers.
package uart_rx_fifo_receiver_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int calc_half_cnt(input int clk_freq, input int uart_bps);
    return calc_bps_cnt(clk_freq, uart_bps) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_receiver_if.sv
// rtl/uart_rx_fifo_receiver_if.sv - byte read port and status between receiver and CPU-side driver
// The driver side is the master; the receiver is the slave.
interface uart_rx_fifo_receiver_if import uart_rx_fifo_receiver_pkg::*; ();

  logic              iRdEn;
  logic [DATA_W-1:0] oRdData;
  logic              oEmpty;
  logic              oFull;
  logic              oFrameErr;
  logic              oOverrun;
  logic              oBusy;

  modport master (
    output iRdEn,
    input  oRdData, oEmpty, oFull, oFrameErr, oOverrun, oBusy
  );

  modport slave (
    input  iRdEn,
    output oRdData, oEmpty, oFull, oFrameErr, oOverrun, oBusy
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - first-word-fall-through byte FIFO with sticky overrun
// Head entry drives rd_data_o combinationally; a push into a full FIFO is dropped unless a pop frees the slot.
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overrun_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q, overrun_q, overrun_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop    = pop_i & ~empty_q;
    do_push   = push_i & (~full_q | do_pop);
    overrun_d = overrun_q | (push_i & full_q & ~do_pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Flags are registered from the next count so they line up with the pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CW'(DEPTH));
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty_o   = empty_q;
  assign full_o    = full_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_fifo_receiver.sv
// rtl/uart_rx_fifo_receiver.sv - oversampling UART receiver feeding a byte FIFO
// Define UART_RX_PARITY_EN for 8E1 framing with an even parity check; default is 8N1.
module uart_rx_fifo_receiver
  import uart_rx_fifo_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int UART_BPS   = 128000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    iFpgaClock,
  input  logic                    iCpuReset,
  input  logic                    iUartFromPc,
  uart_rx_fifo_receiver_if.slave  rd_if
);

  localparam int BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, UART_BPS);
  localparam int BAUD_W   = $clog2(BPS_CNT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_CNT - 1);

  logic              sync1_q, sync2_q, hist_q;
  logic              start_det, rx_bit, baud_last;
  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              push, par_bad;
`ifdef UART_RX_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  // Preset to the idle level so reset release never looks like a start edge.
  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= iUartFromPc;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rx_bit    = sync2_q;
  assign start_det = hist_q & ~sync2_q;
  assign baud_last = (baud_q == BAUD_LAST);
`ifdef UART_RX_PARITY_EN
  assign par_bad   = par_err_q;
`else
  assign par_bad   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d = ST_START;
          baud_d  = '0;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_bit ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {rx_bit, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d    = '0;
          par_err_d = (^shift_q) ^ rx_bit;
          state_d   = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      // Leaving at mid-stop-bit keeps back-to-back frames aligned.
      ST_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          if (rx_bit && !par_bad) push        = 1'b1;
          else                    frame_err_d = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i       (iFpgaClock),
    .rst_i       (iCpuReset),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (rd_if.iRdEn),
    .rd_data_o   (rd_if.oRdData),
    .empty_o     (rd_if.oEmpty),
    .full_o      (rd_if.oFull),
    .overrun_o   (rd_if.oOverrun)
  );

  assign rd_if.oFrameErr = frame_err_q;
  assign rd_if.oBusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// tb/tb_uart_rx_fifo_receiver.sv - self-checking bench for uart_rx_fifo_receiver
// Fast baud divider (16 clk/bit) keeps the run short; expected bytes flow through a scoreboard queue.
module tb_uart_rx_fifo_receiver;

  localparam int CLK_FREQ = 100_000_000;
  localparam int UART_BPS = 6_250_000;
  localparam int BIT      = CLK_FREQ / UART_BPS;
  localparam int HALF     = BIT / 2;
  localparam int DEPTH    = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Two sync flops + history, half a bit to the start sample, then data/(parity)/stop bits.
  localparam int PUSH_LAT = 3 + HALF + (9 + (PAR_EN ? 1 : 0)) * BIT;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_flip;
    logic       exp_store;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rxd;
  always #5 clk = ~clk;

  uart_rx_fifo_receiver_if rd_if ();

  uart_rx_fifo_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .iFpgaClock  (clk),
    .iCpuReset   (rst),
    .iUartFromPc (rxd),
    .rd_if       (rd_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  int t_start  = 0;
  int t_fall   = -1;
  logic empty_prev = 1'b1;
  logic [7:0] exp_q [$];
  vec_t vecs [6];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rd_if.oFrameErr) ferr_cnt = ferr_cnt + 1;
    if (rd_if.oBusy) busy_cnt = busy_cnt + 1;
    if (empty_prev && !rd_if.oEmpty) t_fall = cyc;
    empty_prev = rd_if.oEmpty;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ par_flip);
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic pulse_rd();
    rd_if.iRdEn = 1'b1;
    @(negedge clk);
    rd_if.iRdEn = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got pop request expected scoreboard entry (queue empty)", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, rd_if.oRdData, e);
      check({name, "_nonempty"}, rd_if.oEmpty, 1'b0);
    end
    pulse_rd();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int ferr0, busy0;
    rxd = 1'b1;
    rd_if.iRdEn = 1'b0;
    vecs[0] = '{8'hA3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1'b1, !PAR_EN, PAR_EN};

    do_reset();
    check("rst_rddata", rd_if.oRdData, 8'h00);
    check("rst_empty", rd_if.oEmpty, 1'b1);
    check("rst_full", rd_if.oFull, 1'b0);
    check("rst_ferr", rd_if.oFrameErr, 1'b0);
    check("rst_overrun", rd_if.oOverrun, 1'b0);
    check("rst_busy", rd_if.oBusy, 1'b0);

    // First byte: push latency and FWFT head.
    repeat (2 * BIT) @(negedge clk);
    t_fall = -1;
    send_frame(8'h55, 1'b1, 1'b0);
    exp_q.push_back(8'h55);
    check_range("latency_55", t_fall - t_start, PUSH_LAT - 1, PUSH_LAT + 1);
    pop_check("pop_55");
    check("empty_after_55", rd_if.oEmpty, 1'b1);

    // Pop on empty is ignored.
    pulse_rd();
    @(negedge clk);
    check("pop_empty_empty", rd_if.oEmpty, 1'b1);
    check("pop_empty_full", rd_if.oFull, 1'b0);

    // Short low glitch: busy for the half-bit window only.
    ferr0 = ferr_cnt;
    busy0 = busy_cnt;
    rxd = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_range("glitch_busy", busy_cnt - busy0, HALF - 1, HALF + 1);
    check("glitch_ferr", ferr_cnt - ferr0, 0);
    check("glitch_empty", rd_if.oEmpty, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ferr0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
      repeat (BIT) @(negedge clk);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - ferr0, {31'd0, vecs[i].exp_err});
      if (vecs[i].exp_store) begin
        exp_q.push_back(vecs[i].data);
        pop_check($sformatf("vec%0d_pop", i));
      end
      check($sformatf("vec%0d_empty", i), rd_if.oEmpty, 1'b1);
    end

    // Back-to-back frames overflow the FIFO.
    for (int k = 0; k < 5; k++) begin
      send_frame(8'hA1 + 8'(k), 1'b1, 1'b0);
      if (k < 4) exp_q.push_back(8'hA1 + 8'(k));
      if (k == 2) check("b2b_notfull", rd_if.oFull, 1'b0);
      if (k == 3) begin
        check("b2b_full4", rd_if.oFull, 1'b1);
        check("b2b_noovr4", rd_if.oOverrun, 1'b0);
      end
    end
    check("b2b_overrun", rd_if.oOverrun, 1'b1);
    check("b2b_full5", rd_if.oFull, 1'b1);
    repeat (BIT) @(negedge clk);
    for (int k = 0; k < 4; k++) pop_check($sformatf("b2b_pop%0d", k));
    check("b2b_empty", rd_if.oEmpty, 1'b1);
    check("b2b_sticky", rd_if.oOverrun, 1'b1);

    do_reset();
    check("rst2_overrun", rd_if.oOverrun, 1'b0);
    exp_q.delete();

    // Full FIFO with a pop on the exact push cycle.
    for (int k = 0; k < 4; k++) begin
      send_frame(8'hB1 + 8'(k), 1'b1, 1'b0);
      exp_q.push_back(8'hB1 + 8'(k));
    end
    check("fullpop_pre_full", rd_if.oFull, 1'b1);
    fork
      send_frame(8'hB0, 1'b1, 1'b0);
      begin
        repeat (PUSH_LAT - 1) @(negedge clk);
        pop_check("fullpop_head");
        exp_q.push_back(8'hB0);
      end
    join
    repeat (BIT) @(negedge clk);
    check("fullpop_overrun", rd_if.oOverrun, 1'b0);
    check("fullpop_full", rd_if.oFull, 1'b1);
    for (int k = 0; k < 4; k++) pop_check($sformatf("fullpop_pop%0d", k));
    check("fullpop_empty", rd_if.oEmpty, 1'b1);

    // Empty FIFO with a pop on the push cycle: push wins, pop ignored.
    fork
      send_frame(8'h42, 1'b1, 1'b0);
      begin
        repeat (PUSH_LAT - 1) @(negedge clk);
        pulse_rd();
      end
    join
    exp_q.push_back(8'h42);
    repeat (BIT) @(negedge clk);
    pop_check("emptypop_42");
    check("emptypop_empty", rd_if.oEmpty, 1'b1);

    // Reset in the middle of a data phase aborts the frame.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("middata_busy", rd_if.oBusy, 1'b1);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("middata_rst_busy", rd_if.oBusy, 1'b0);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("middata_empty", rd_if.oEmpty, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    exp_q.push_back(8'h81);
    repeat (BIT) @(negedge clk);
    pop_check("after_rst_81");
    check("after_rst_empty", rd_if.oEmpty, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_receiver.md
Name: uart_rx_fifo_receiver

Overview:
Serial-to-byte front end that feeds the CPU-side UART driver. Samples the PC-driven rxd line in the iFpgaClock domain and validates start, data, stop (and optional parity) bits. Completed bytes are pushed into a small first-word-fall-through FIFO. The downstream driver pops bytes from this FIFO instead of seeing only the last received byte.

Parameters:
CLK_FREQ, 100_000_000, iFpgaClock frequency in Hz
UART_BPS, 128000, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer, 781 at defaults), HALF_CNT = BPS_CNT/2 (390)
FIFO_DEPTH, 4, byte entries; power of two, minimum 2

Ports:
iFpgaClock  in  1  sampling/FIFO clock
iCpuReset  in  1  reset, asynchronous, active-high
iUartFromPc  in  1  serial rxd from PC, idle high, asynchronous
iRdEn  in  1  pop head byte; single-cycle pulse in the iFpgaClock domain
oRdData  out  8  head of FIFO; valid while oEmpty=0
oEmpty  out  1  FIFO holds no bytes
oFull  out  1  FIFO holds FIFO_DEPTH bytes
oFrameErr  out  1  one-cycle pulse on bad stop (or parity) bit
oOverrun  out  1  sticky: a good byte arrived while full and was dropped
oBusy  out  1  receiver FSM not in IDLE

Behaviour:
- Reset (async, iCpuReset=1) drives the following; reset mid-frame aborts the frame and nothing is pushed:
  - oRdData=0, oEmpty=1, oFull=0, oFrameErr=0, oOverrun=0, oBusy=0
  - FSM=IDLE, pointers/count=0
  - sync flops preset to 1 (line idle)
- Input sync: 2-flop synchronizer plus one history flop. Start detect = synced line falling edge (prev=1, cur=0).
- FSM:
  - IDLE -> START on start detect; bit counter cleared, baud counter cleared.
  - START: baud counter counts to HALF_CNT-1. At HALF_CNT-1, sample the line: 0 -> DATA (baud counter restarts); 1 -> IDLE (glitch rejected, no error).
  - DATA: each time the baud counter reaches BPS_CNT-1, sample one bit into the shift register, LSB first. After the 8th bit -> STOP, or -> PARITY when the feature is enabled.
  - STOP: sample at BPS_CNT-1.
    - Sample 1: push byte; -> IDLE.
    - Sample 0: oFrameErr pulses for one cycle, byte discarded; -> IDLE.
  - Return to IDLE happens at mid-stop-bit so back-to-back frames are caught. A held-low break line produces no new start, because start needs a falling edge.
- Push latency: the byte is visible on oRdData and oEmpty falls on the clock after the stop-bit sample (FIFO previously empty).
- FIFO:
  - First-word-fall-through; oRdData is combinational from the head entry.
  - Count width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - Pop when empty is ignored; state unchanged.
  - Push when full without a pop: byte dropped, oOverrun set and held until reset.
  - Push and pop in the same cycle:
    - Full: both occur, count unchanged, no overrun.
    - Empty: push only; the pop is ignored.
- oFull and oEmpty are registered from the next count value and are never both 1.
- oBusy = (state != IDLE).

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and samples one bit at BPS_CNT-1. The even parity check covers the 8 data bits plus the parity bit, whose XOR must be 0. On mismatch, STOP is still sampled, then the byte is discarded and oFrameErr pulses, even if the stop bit was good.
- Not defined: frame is 8N1; no PARITY state exists.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - BPS_CNT/HALF_CNT derivation function
  - data width constant 8
- One natural sub-module: uart_byte_fifo, a parameterised FWFT FIFO with push/pop/full/empty/overrun. The receiver FSM and synchronizer stay in the top.

Test Plan:
- Send 0x55 as 8N1 at 781 clk/bit, idle before and after -> oEmpty falls about 7420 cycles after the start edge (START 390 + 8 data bits + stop at 781 each), oRdData=0x55. Pulse iRdEn -> oEmpty=1.
- Low glitch of 200 cycles on idle rxd -> oBusy high for about 390 cycles then IDLE; no push, oFrameErr never pulses.
- Frame 0xA3 with stop bit 0 -> single-cycle oFrameErr, oEmpty stays 1. A following good frame 0x3C is received correctly.
- Five back-to-back frames 0xA1..0xA5, no pops:
  - oFull=1 after the 4th frame; oOverrun=1 after the 5th.
  - Popping 4 times yields 0xA1, 0xA2, 0xA3, 0xA4, then oEmpty=1.
- FIFO full, iRdEn asserted on the exact push cycle of 0xB0 -> oOverrun stays 0, count stays 4, last entry read is 0xB0.
- Assert iCpuReset mid-DATA of 0x7E, release, send 0x81 -> only 0x81 is stored. With UART_RX_PARITY_EN, 0x81 with parity bit 1 -> oFrameErr pulses and nothing is stored.
